apb_master_bridge: RTL and testbench

//  APB3 requester: turns single-beat commands from a local valid/ready port into
//  APB transfers (IDLE->SETUP->ACCESS) on the bus that feeds apb_sl_dut-style

---
 rtl/apb_master_bridge.sv | 161 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3 requester: single-beat valid/ready commands become IDLE/SETUP/ACCESS transfers.
// Each finished or timed-out transfer returns one rsp_valid pulse.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_hit;

    // A new command is taken in IDLE or on the completing ACCESS cycle only.
    assign cmd_ready   = (state_q == S_IDLE) || ((state_q == S_ACCESS) && pready);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    penable_d     = 1'b0;
                    // Back-to-back: keep psel high and go straight to SETUP.
                    if (cmd_valid) begin
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_wdata;
                        psel_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_SETUP;
                    end else begin
                        psel_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= S_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized traffic against
// a transaction-age model and a small APB completer with memory.
module tb_apb_master_bridge;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic          pclk;
    logic          presetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    int n_cmp;
    int n_err;

    // Model: a transfer is "age" cycles past its accept edge (1 = setup, >=2 = access).
    bit            m_busy;
    int            m_age;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_rsp_valid;
    logic [DW-1:0] m_rsp_rdata;
    logic          m_rsp_err, m_rsp_to;
    bit            m_acc;
    bit            rdy;
    bit [DW-1:0]   mem [256];

    int pready_mode;
    bit err_en;
    int stall_req;
    int stall_used;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completer: drives pready/pslverr/prdata away from the active edge.
    always @(negedge pclk) begin
        bit in_acc;
        in_acc = m_busy && (m_age >= 2);
        if (in_acc && (stall_used < stall_req)) begin
            pready = 1'b0;
            stall_used++;
        end else begin
            case (pready_mode)
                0:       pready = 1'b1;
                1:       pready = ($urandom_range(0, 3) != 0);
                default: pready = 1'b0;
            endcase
        end
        pslverr = in_acc ? ((m_addr == 8'hC9) || (err_en && ($urandom_range(0, 7) == 0)))
                         : 1'($urandom);
        prdata  = (in_acc && !m_write) ? mem[m_addr] : 8'($urandom);
    end

    // Model update on each edge, then compare every output.
    always @(posedge pclk) begin
        if (!presetn) begin
            m_busy      = 1'b0;
            m_age       = 0;
            m_rsp_valid = 1'b0;
            m_acc       = 1'b0;
        end else begin
            m_rsp_valid = 1'b0;
            m_acc       = 1'b0;
            rdy = !m_busy || ((m_age >= 2) && pready);
            if (m_busy && (m_age >= 2)) begin
                if (pready) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_err   = pslverr;
                    m_rsp_to    = 1'b0;
                    m_rsp_rdata = m_write ? 8'h00 : prdata;
                    if (m_write && !pslverr) mem[m_addr] = m_wdata;
                    m_busy = 1'b0;
                end else if ((TO != 0) && ((m_age - 1) == int'(TO))) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_err   = 1'b1;
                    m_rsp_to    = 1'b1;
                    m_rsp_rdata = 8'h00;
                    m_busy      = 1'b0;
                end else begin
                    m_age++;
                end
            end else if (m_busy) begin
                m_age++;
            end
            if (rdy && cmd_valid) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_write = cmd_write;
                m_addr  = cmd_addr;
                m_wdata = cmd_wdata;
                m_acc   = 1'b1;
            end
        end
        #1;
        chk("psel", psel, m_busy);
        chk("penable", penable, m_busy && (m_age >= 2));
        if (m_busy) begin
            chk("paddr", paddr, m_addr);
            chk("pwrite", pwrite, m_write);
            chk("pwdata", pwdata, m_wdata);
        end
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        if (m_rsp_valid) begin
            chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
            chk("rsp_err", rsp_err, m_rsp_err);
            chk("rsp_timeout", rsp_timeout, m_rsp_to);
        end
        @(negedge pclk);
        #1;
        chk("cmd_ready", cmd_ready, !presetn || !m_busy || ((m_age >= 2) && pready));
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 64; i++) begin
            @(posedge pclk);
            #1;
            if (m_acc) return;
        end
        chk("accept_wait", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic run_one(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int acc, output int lat, output logic [DW-1:0] rd,
                           output logic e, output logic t);
        bit got;
        send(w, a, d);
        cmd_valid = 1'b0;
        chk("setup_phase", {psel, penable}, 2'b10);
        acc = 0;
        lat = 1;
        got = 1'b0;
        rd  = 'x;
        e   = 1'bx;
        t   = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(posedge pclk);
            #1;
            lat++;
            if (penable) acc++;
            if (rsp_valid) begin
                got = 1'b1;
                rd  = rsp_rdata;
                e   = rsp_err;
                t   = rsp_timeout;
                break;
            end
        end
        if (!got) chk("rsp_wait", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int            acc, lat, pulses;
        logic [DW-1:0] rd;
        logic          e, t;

        presetn     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        pready      = 1'b1;
        pslverr     = 1'b0;
        prdata      = '0;
        pready_mode = 0;
        err_en      = 1'b0;
        stall_req   = 0;

        repeat (3) @(posedge pclk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        #1;

        // Zero-wait write.
        run_one(1'b1, 8'h10, 8'hA5, acc, lat, rd, e, t);
        chk("t1_access_cycles", acc, 1);
        chk("t1_latency", lat, 3);
        chk("t1_err", e, 0);
        chk("t1_rdata", rd, 8'h00);

        // Read back the written byte.
        run_one(1'b0, 8'h10, 8'h00, acc, lat, rd, e, t);
        chk("t2_latency", lat, 3);
        chk("t2_rdata", rd, 8'hA5);
        chk("t2_err", e, 0);

        // Completer error.
        run_one(1'b0, 8'hC9, 8'h00, acc, lat, rd, e, t);
        chk("t3_err", e, 1);
        chk("t3_timeout", t, 0);

        // Three wait states.
        stall_req += 3;
        run_one(1'b0, 8'h10, 8'h00, acc, lat, rd, e, t);
        chk("t4_access_cycles", acc, 4);
        chk("t4_latency", lat, 6);
        chk("t4_rdata", rd, 8'hA5);

        // Stuck completer -> timeout, then normal traffic resumes.
        pready_mode = 2;
        run_one(1'b1, 8'h33, 8'h5A, acc, lat, rd, e, t);
        chk("t5_access_cycles", acc, 16);
        chk("t5_err", e, 1);
        chk("t5_timeout", t, 1);
        chk("t5_rdata", rd, 8'h00);
        chk("t5_psel_dropped", psel, 0);
        pready_mode = 0;
        run_one(1'b0, 8'h10, 8'h00, acc, lat, rd, e, t);
        chk("t5_next_rdata", rd, 8'hA5);
        chk("t5_next_timeout", t, 0);

        // Back-to-back, then reset during the second SETUP.
        send(1'b1, 8'h01, 8'h11);
        send(1'b0, 8'h02, 8'h00);
        chk("t6_first_rsp", rsp_valid, 1);
        chk("t6_second_setup", {psel, penable}, 2'b10);
        chk("t6_second_addr", paddr, 8'h02);
        cmd_valid = 1'b0;
        #2;
        presetn = 1'b0;
        #1;
        chk("t6_rst_psel", psel, 0);
        chk("t6_rst_penable", penable, 0);
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(posedge pclk);
            #1;
            if (rsp_valid) pulses++;
        end
        chk("t6_no_second_rsp", pulses, 0);

        // Randomized traffic.
        pready_mode = 1;
        err_en      = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge pclk);
            #2;
            if (m_acc || !cmd_valid) begin
                cmd_valid = ($urandom_range(0, 9) < 6);
                cmd_write = 1'($urandom);
                cmd_addr  = ($urandom_range(0, 15) == 0) ? 8'hC9 : 8'($urandom_range(0, 31));
                cmd_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 59) == 0) stall_req += $urandom_range(4, 20);
            if ($urandom_range(0, 499) == 0) begin
                presetn = 1'b0;
                @(posedge pclk);
                @(negedge pclk);
                presetn = 1'b1;
            end
        end
        cmd_valid   = 1'b0;
        pready_mode = 0;
        repeat (40) @(posedge pclk);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
